// File: rtl/glyph_pkg.sv
// Shared constants for the glyph pixel pipeline: attribute bit positions,
// default glyph geometry, font image name and a width helper.
package glyph_pkg;

  // Bit positions inside the 4-bit attribute field {cursor, blink, underline, inverse}
  localparam int ATTR_INVERSE   = 0;
  localparam int ATTR_UNDERLINE = 1;
  localparam int ATTR_BLINK     = 2;
  localparam int ATTR_CURSOR    = 3;

  localparam int GLYPH_W_DEF = 8;
  localparam int GLYPH_H_DEF = 8;

  // Font image loaded into the font RAM by the device configuration flow
  localparam string FONT_INIT_FILE = "glyph_font.mem";

  // Ceiling log2, never below 1 so that single-entry fields still get a bit
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/glyph_font_ram.sv
// Simple dual-port font RAM: one write port, one registered read port.
// A read and a write to the same address in one cycle return the old word.
module glyph_font_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2048,
  parameter int AW    = 11
) (
  input  logic             clk,
  input  logic             wrEn,
  input  logic [AW-1:0]    wrAddr,
  input  logic [WIDTH-1:0] wrData,
  input  logic [AW-1:0]    rdAddr,
  output logic [WIDTH-1:0] rdData
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write and read share the edge; the non-blocking update makes the read see the old word
  always_ff @(posedge clk) begin
    if (wrEn) mem[wrAddr] <= wrData;
    rdData <= mem[rdAddr];
  end

endmodule

// File: rtl/glyph_pixel_pipe.sv
// Character cell to pixel lookup: font RAM read followed by attribute
// processing (underline, blink, inverse, cursor), fixed 3-cycle latency.
module glyph_pixel_pipe
  import glyph_pkg::*;
#(
  parameter int GLYPH_W      = GLYPH_W_DEF,
  parameter int GLYPH_H      = GLYPH_H_DEF,
  parameter int SCALE_LOG2   = 0,
  parameter int BLINK_FRAMES = 30,
  parameter int CURSOR_TOP   = GLYPH_H - 2,
  localparam int CHW   = clog2(GLYPH_W),
  localparam int RHW   = clog2(GLYPH_H),
  localparam int COL_W = CHW + SCALE_LOG2,
  localparam int ROW_W = RHW + SCALE_LOG2,
  localparam int AW    = 8 + RHW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               in_valid,
  input  logic [7:0]         in_char,
  input  logic [COL_W-1:0]   in_col,
  input  logic [ROW_W-1:0]   in_row,
  input  logic [3:0]         in_attr,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [GLYPH_W-1:0] wr_data,
  output logic               out_valid,
  output logic               out_pixel,
  output logic               blink_phase
);

  localparam int WP = 1 << CHW;
  localparam int BW = clog2(BLINK_FRAMES);

  localparam logic [CHW:0]    GW_C       = (CHW + 1)'(GLYPH_W);
  localparam logic [RHW:0]    GH_C       = (RHW + 1)'(GLYPH_H);
  localparam logic [RHW:0]    CT_C       = (RHW + 1)'(CURSOR_TOP);
  localparam logic [RHW-1:0]  GH_LAST    = RHW'(GLYPH_H - 1);
  localparam logic [BW-1:0]   BLINK_LAST = BW'(BLINK_FRAMES - 1);
  localparam logic [AW-1:0]   GH_A       = AW'(GLYPH_H);

  logic [CHW-1:0]     gcIn;
  logic [RHW-1:0]     grIn;
  logic [AW-1:0]      rdAddr;
  logic [7:0]         wrChar;
  logic [RHW-1:0]     wrRow;
  logic [AW-1:0]      wrIdx;
  logic               wrOk;

  logic               vld_p0, vld_p1, vld_p2;
  logic [CHW-1:0]     gc_p0, gc_p1;
  logic [RHW-1:0]     gr_p0, gr_p1;
  logic [3:0]         attr_p0, attr_p1;
  logic [GLYPH_W-1:0] word_p0, word_p1;
  logic [WP-1:0]      wordPad_p1;
  logic               pix_p2;

  logic [BW-1:0]      blinkCnt;
  logic               blinkPhase;

  // Attribute stack applied to one glyph bit; out-of-glyph positions are always background
  function automatic logic shadePixel(input logic [WP-1:0]  word,
                                      input logic [CHW-1:0] gc,
                                      input logic [RHW-1:0] gr,
                                      input logic [3:0]     attr,
                                      input logic           phase);
    logic g;
    logic p;
    g = word[gc];
    if (attr[ATTR_UNDERLINE] && (gr == GH_LAST)) g = 1'b1;
    if (attr[ATTR_BLINK] && phase) g = 1'b0;
    p = g ^ attr[ATTR_INVERSE];
    if (attr[ATTR_CURSOR] && !phase && ({1'b0, gr} >= CT_C)) p = ~p;
    if (({1'b0, gc} >= GW_C) || ({1'b0, gr} >= GH_C)) p = 1'b0;
    return p;
  endfunction

  // Integer scaling drops the low bits; font RAM is packed densely as char*GLYPH_H + row
  assign gcIn   = in_col[COL_W-1:SCALE_LOG2];
  assign grIn   = in_row[ROW_W-1:SCALE_LOG2];
  assign rdAddr = AW'(in_char) * GH_A + (({1'b0, grIn} < GH_C) ? AW'(grIn) : '0);

  assign wrChar = wr_addr[AW-1:RHW];
  assign wrRow  = wr_addr[RHW-1:0];
  assign wrIdx  = AW'(wrChar) * GH_A + AW'(wrRow);
  assign wrOk   = wr_en && ({1'b0, wrRow} < GH_C);

  glyph_font_ram #(
    .WIDTH (GLYPH_W),
    .DEPTH (256 * GLYPH_H),
    .AW    (AW)
  ) uFontRam (
    .clk    (clk),
    .wrEn   (wrOk),
    .wrAddr (wrIdx),
    .wrData (wr_data),
    .rdAddr (rdAddr),
    .rdData (word_p0)
  );

  // ---- S1: capture request; font RAM read launched from the raw inputs ----
  // Valid bit for stage 1
  always_ff @(posedge clk) begin
    if (rst) vld_p0 <= 1'b0;
    else     vld_p0 <= in_valid;
  end

  // Cell coordinates and attributes for stage 1
  always_ff @(posedge clk) begin
    gc_p0   <= gcIn;
    gr_p0   <= grIn;
    attr_p0 <= in_attr;
  end

  // ---- S2: font word arrives; sideband carried alongside ----
  // Valid bit for stage 2
  always_ff @(posedge clk) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= vld_p0;
  end

  // Font word and sideband for stage 2
  always_ff @(posedge clk) begin
    gc_p1   <= gc_p0;
    gr_p1   <= gr_p0;
    attr_p1 <= attr_p0;
    word_p1 <= word_p0;
  end

  assign wordPad_p1 = WP'(word_p1);

  // ---- S3: attribute processing, blink phase sampled here ----
  // Output register; pixel held low whenever the slot is empty
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2 <= 1'b0;
      pix_p2 <= 1'b0;
    end else begin
      vld_p2 <= vld_p1;
      pix_p2 <= vld_p1 ? shadePixel(wordPad_p1, gc_p1, gr_p1, attr_p1, blinkPhase) : 1'b0;
    end
  end

  // Blink divider: phase flips every BLINK_FRAMES frame ticks
  always_ff @(posedge clk) begin
    if (rst) begin
      blinkCnt   <= '0;
      blinkPhase <= 1'b0;
    end else if (frame_tick) begin
      if (blinkCnt == BLINK_LAST) begin
        blinkCnt   <= '0;
        blinkPhase <= ~blinkPhase;
      end else begin
        blinkCnt <= blinkCnt + 1'b1;
      end
    end
  end

  assign out_valid   = vld_p2;
  assign out_pixel   = pix_p2;
  assign blink_phase = blinkPhase;

endmodule

// File: tb/tb_glyph_pixel_pipe.sv
// Directed bench: instance A is the default 8x8 geometry with a short blink
// period, instance B is a 6-wide glyph with 2x scaling.
module tb_glyph_pixel_pipe;

  logic clk;
  logic rst;
  logic frameTick;

  logic        aValid, aWrEn, aOutValid, aOutPixel, aBlink;
  logic [7:0]  aChar;
  logic [2:0]  aCol, aRow;
  logic [3:0]  aAttr;
  logic [10:0] aWrAddr;
  logic [7:0]  aWrData;

  logic        bValid, bWrEn, bOutValid, bOutPixel, bBlink;
  logic [7:0]  bChar;
  logic [3:0]  bCol, bRow;
  logic [3:0]  bAttr;
  logic [10:0] bWrAddr;
  logic [5:0]  bWrData;

  int checks;
  int errors;

  glyph_pixel_pipe #(
    .GLYPH_W(8), .GLYPH_H(8), .SCALE_LOG2(0), .BLINK_FRAMES(2)
  ) dutA (
    .clk(clk), .rst(rst), .frame_tick(frameTick),
    .in_valid(aValid), .in_char(aChar), .in_col(aCol), .in_row(aRow), .in_attr(aAttr),
    .wr_en(aWrEn), .wr_addr(aWrAddr), .wr_data(aWrData),
    .out_valid(aOutValid), .out_pixel(aOutPixel), .blink_phase(aBlink)
  );

  glyph_pixel_pipe #(
    .GLYPH_W(6), .GLYPH_H(8), .SCALE_LOG2(1), .BLINK_FRAMES(30)
  ) dutB (
    .clk(clk), .rst(rst), .frame_tick(frameTick),
    .in_valid(bValid), .in_char(bChar), .in_col(bCol), .in_row(bRow), .in_attr(bAttr),
    .wr_en(bWrEn), .wr_addr(bWrAddr), .wr_data(bWrData),
    .out_valid(bOutValid), .out_pixel(bOutPixel), .blink_phase(bBlink)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic writeA(input logic [7:0] ch, input logic [2:0] row, input logic [7:0] data);
    aWrEn = 1'b1; aWrAddr = {ch, row}; aWrData = data;
    tick();
    aWrEn = 1'b0;
  endtask

  task automatic writeB(input logic [7:0] ch, input logic [2:0] row, input logic [5:0] data);
    bWrEn = 1'b1; bWrAddr = {ch, row}; bWrData = data;
    tick();
    bWrEn = 1'b0;
  endtask

  // Single isolated request on A, checked three cycles later
  task automatic reqA(input logic [7:0] ch, input logic [2:0] col, input logic [2:0] row,
                      input logic [3:0] attr, input string tag, input logic expPix);
    aValid = 1'b1; aChar = ch; aCol = col; aRow = row; aAttr = attr;
    tick();
    aValid = 1'b0;
    tick();
    tick();
    checkVal({tag, ".valid"}, aOutValid, 1);
    checkVal(tag, aOutPixel, expPix);
  endtask

  task automatic reqB(input logic [7:0] ch, input logic [3:0] col, input logic [3:0] row,
                      input logic [3:0] attr, input string tag, input logic expPix);
    bValid = 1'b1; bChar = ch; bCol = col; bRow = row; bAttr = attr;
    tick();
    bValid = 1'b0;
    tick();
    tick();
    checkVal({tag, ".valid"}, bOutValid, 1);
    checkVal(tag, bOutPixel, expPix);
  endtask

  initial begin
    logic [7:0] expRow;
    checks = 0;
    errors = 0;
    rst = 1'b1; frameTick = 1'b0;
    aValid = 0; aWrEn = 0; aChar = 0; aCol = 0; aRow = 0; aAttr = 0; aWrAddr = 0; aWrData = 0;
    bValid = 0; bWrEn = 0; bChar = 0; bCol = 0; bRow = 0; bAttr = 0; bWrAddr = 0; bWrData = 0;
    tick();
    tick();

    // Reset state
    checkVal("rst.aValid", aOutValid, 0);
    checkVal("rst.aPixel", aOutPixel, 0);
    checkVal("rst.aBlink", aBlink, 0);
    checkVal("rst.bValid", bOutValid, 0);
    checkVal("rst.bBlink", bBlink, 0);
    rst = 1'b0;
    tick();

    // Font load
    writeA(8'h41, 3'd0, 8'b00011000);
    writeA(8'h20, 3'd6, 8'h00);
    writeA(8'h20, 3'd7, 8'h00);
    writeA(8'h42, 3'd2, 8'h01);
    writeB(8'h41, 3'd0, 6'b000001);

    // Back-to-back stream of 'A' row 0: exact 3-cycle latency, 8 valid outputs
    expRow = 8'b00011000;
    for (int t = 0; t < 12; t++) begin
      checkVal($sformatf("stream.valid%0d", t), aOutValid, (t >= 3 && t < 11));
      if (t >= 3 && t < 11) checkVal($sformatf("stream.pix%0d", t - 3), aOutPixel, expRow[t - 3]);
      else                  checkVal($sformatf("stream.idle%0d", t), aOutPixel, 0);
      if (t < 8) begin
        aValid = 1'b1; aChar = 8'h41; aCol = 3'(t); aRow = 3'd0; aAttr = 4'd0;
      end else begin
        aValid = 1'b0;
      end
      tick();
    end

    // Read-first: write 0x41 row 0 = FF in the same cycle as a read of it
    aValid = 1'b1; aChar = 8'h41; aCol = 3'd0; aRow = 3'd0; aAttr = 4'd0;
    aWrEn = 1'b1; aWrAddr = {8'h41, 3'd0}; aWrData = 8'hFF;
    tick();
    aWrEn = 1'b0;
    tick();
    aValid = 1'b0;
    tick();
    checkVal("rdfirst.old", aOutPixel, 0);
    tick();
    checkVal("rdfirst.newValid", aOutValid, 1);
    checkVal("rdfirst.new", aOutPixel, 1);
    tick();

    // Underline / inverse on the blank character
    reqA(8'h20, 3'd0, 3'd7, 4'b0010, "ul.col0", 1);
    reqA(8'h20, 3'd3, 3'd7, 4'b0010, "ul.col3", 1);
    reqA(8'h20, 3'd7, 3'd7, 4'b0010, "ul.col7", 1);
    reqA(8'h20, 3'd2, 3'd7, 4'b0011, "ulinv.row7", 0);
    reqA(8'h20, 3'd2, 3'd6, 4'b0011, "ulinv.row6", 1);

    // Blink and cursor
    reqA(8'h42, 3'd0, 3'd2, 4'b0100, "blink.shown", 1);
    reqA(8'h20, 3'd0, 3'd7, 4'b1000, "cursor.on", 1);
    reqA(8'h20, 3'd0, 3'd5, 4'b1000, "cursor.above", 0);
    frameTick = 1'b1;
    tick();
    checkVal("blink.after1", aBlink, 0);
    tick();
    frameTick = 1'b0;
    checkVal("blink.phase1", aBlink, 1);
    checkVal("blink.bStill0", bBlink, 0);
    reqA(8'h42, 3'd0, 3'd2, 4'b0100, "blink.hidden", 0);
    reqA(8'h42, 3'd0, 3'd2, 4'b0000, "blink.noattr", 1);
    reqA(8'h20, 3'd0, 3'd7, 4'b1000, "cursor.hidden", 0);
    reqA(8'h20, 3'd0, 3'd7, 4'b1001, "cursor.hiddenInv", 1);
    frameTick = 1'b1;
    tick();
    frameTick = 1'b0;
    checkVal("blink.still1", aBlink, 1);
    tick();
    frameTick = 1'b1;
    tick();
    frameTick = 1'b0;
    checkVal("blink.phase0", aBlink, 0);

    // Narrow glyph with 2x scaling
    reqB(8'h41, 4'd0, 4'd0, 4'b0000, "scale.col0", 1);
    reqB(8'h41, 4'd1, 4'd1, 4'b0000, "scale.col1", 1);
    reqB(8'h41, 4'd2, 4'd0, 4'b0000, "scale.col2", 0);
    reqB(8'h41, 4'd10, 4'd0, 4'b0001, "scale.col10inv", 1);
    for (int c = 12; c < 16; c++)
      reqB(8'h41, 4'(c), 4'd0, 4'b0001, $sformatf("scale.outside%0d", c), 0);

    // Reset while three requests are in flight; blink counter parked at 1 with phase 1
    frameTick = 1'b1;
    tick();
    tick();
    tick();
    frameTick = 1'b0;
    checkVal("mid.prePhase", aBlink, 1);
    aValid = 1'b1; aChar = 8'h41; aCol = 3'd0; aRow = 3'd0; aAttr = 4'd0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    aValid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checkVal($sformatf("mid.valid%0d", k), aOutValid, 0);
      checkVal($sformatf("mid.pixel%0d", k), aOutPixel, 0);
      tick();
    end
    checkVal("mid.phase", aBlink, 0);
    frameTick = 1'b1;
    tick();
    frameTick = 1'b0;
    checkVal("mid.cnt1", aBlink, 0);
    frameTick = 1'b1;
    tick();
    frameTick = 1'b0;
    checkVal("mid.cnt2", aBlink, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
